// File: rtl/mdu_iterative.sv
// Multiply/divide unit with architectural HI/LO: fixed-latency multiply, radix-2 restoring divide.
// Optional cancel/flush input is enabled by defining MDU_CANCEL_EN.
module mdu_iterative #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic             unsigned_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
`ifdef MDU_CANCEL_EN
  input  logic             cancel,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int MAXCNT = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
  localparam int CNT_W  = $clog2(MAXCNT) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   opA_q, opB_q, divMag_q, rem_q, quo_q, hi_q, lo_q;
  logic               uns_q, negQ_q, negR_q, divZero_q, busy_q, done_q;

  logic               cancelIn;
  logic               negA_d, negB_d;
  logic [WIDTH-1:0]   magA_d, magB_d;
  logic [2*WIDTH-1:0] extA_d, extB_d, prod_d;
  logic [WIDTH:0]     shifted_d, trial_d;
  logic [WIDTH-1:0]   remNext_d, quoNext_d, loFix_d, hiFix_d;

`ifdef MDU_CANCEL_EN
  assign cancelIn = cancel;
`else
  assign cancelIn = 1'b0;
`endif

  // Magnitudes feed the iterator; signs are re-applied in FIX.
  always_comb begin
    negA_d = !unsigned_op && op_a[WIDTH-1];
    negB_d = !unsigned_op && op_b[WIDTH-1];
    magA_d = negA_d ? (~op_a + 1'b1) : op_a;
    magB_d = negB_d ? (~op_b + 1'b1) : op_b;

    extA_d = {{WIDTH{!uns_q && opA_q[WIDTH-1]}}, opA_q};
    extB_d = {{WIDTH{!uns_q && opB_q[WIDTH-1]}}, opB_q};
    prod_d = extA_d * extB_d;

    shifted_d = {rem_q, quo_q[WIDTH-1]};
    trial_d   = shifted_d - {1'b0, divMag_q};
    remNext_d = trial_d[WIDTH] ? shifted_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
    quoNext_d = {quo_q[WIDTH-2:0], !trial_d[WIDTH]};

    // MIN / -1 falls out naturally: negating 2^(W-1) wraps back to MIN.
    loFix_d = divZero_q ? '1    : (negQ_q ? (~quo_q + 1'b1) : quo_q);
    hiFix_d = divZero_q ? opA_q : (negR_q ? (~rem_q + 1'b1) : rem_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      divMag_q  <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      uns_q     <= 1'b0;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
      divZero_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cancelIn && busy_q) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
            if (!cancelIn && (start_mul || start_div)) begin
              opA_q     <= op_a;
              opB_q     <= op_b;
              uns_q     <= unsigned_op;
              divMag_q  <= magB_d;
              quo_q     <= magA_d;
              rem_q     <= '0;
              negQ_q    <= negA_d ^ negB_d;
              negR_q    <= negA_d;
              divZero_q <= (op_b == '0);
              cnt_q     <= '0;
              busy_q    <= 1'b1;
              state_q   <= start_mul ? MUL : DIV;
            end
          end
          MUL: begin
            if (cnt_q == CNT_W'(MUL_LATENCY - 1)) begin
              hi_q    <= prod_d[2*WIDTH-1:WIDTH];
              lo_q    <= prod_d[WIDTH-1:0];
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          DIV: begin
            rem_q <= remNext_d;
            quo_q <= quoNext_d;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              cnt_q   <= '0;
              state_q <= FIX;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          FIX: begin
            hi_q    <= hiFix_d;
            lo_q    <= loFix_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative (WIDTH=32, MUL_LATENCY=4).
// Define MDU_CANCEL_EN for both files to exercise the cancel path.
module tb_mdu_iterative;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          startMul = 1'b0, startDiv = 1'b0, unsignedOp = 1'b0;
  logic [W-1:0]  opA = '0, opB = '0, wData = '0;
  logic          mtHi = 1'b0, mtLo = 1'b0;
`ifdef MDU_CANCEL_EN
  logic          cancelIn = 1'b0;
`endif
  logic [W-1:0]  hiOut, loOut;
  logic          busyOut, doneOut;

  int testsRun = 0;
  int testsFailed = 0;

  mdu_iterative #(.WIDTH(W), .MUL_LATENCY(4)) dut (
    .clk(clk), .rst_n(rstN),
    .start_mul(startMul), .start_div(startDiv), .unsigned_op(unsignedOp),
    .op_a(opA), .op_b(opB),
    .mthi(mtHi), .mtlo(mtLo), .wdata(wData),
`ifdef MDU_CANCEL_EN
    .cancel(cancelIn),
`endif
    .hi(hiOut), .lo(loOut), .busy(busyOut), .done(doneOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One-cycle start pulse; returns #1 after the sampling edge.
  task automatic applyStimulus(input logic mul, input logic div, input logic uns,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    startMul = mul; startDiv = div; unsignedOp = uns; opA = a; opB = b;
    @(posedge clk); #1;
    startMul = 1'b0; startDiv = 1'b0;
  endtask

  // Counts edges until done is seen; -1 if the bound expires.
  task automatic waitDone(input int limit, output int cycles);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < limit) begin
      @(posedge clk); #1;
      n++;
      if (doneOut) seen = 1;
    end
    cycles = seen ? n : -1;
  endtask

  task automatic divCheck(input string tag, input logic uns, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] expLo, input logic [W-1:0] expHi);
    int c;
    applyStimulus(1'b0, 1'b1, uns, a, b);
    waitDone(40, c);
    checkOutput({tag, " latency"}, 64'(c), 64'd33);
    checkOutput({tag, " hilo"}, {hiOut, loOut}, {expHi, expLo});
  endtask

  task automatic mulCheck(input string tag, input logic uns, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] expProd);
    int c;
    applyStimulus(1'b1, 1'b0, uns, a, b);
    waitDone(10, c);
    checkOutput({tag, " latency"}, 64'(c), 64'd4);
    checkOutput({tag, " hilo"}, {hiOut, loOut}, expProd);
  endtask

  initial begin
    int c, doneCount, doneAt;
    logic [W-1:0] capHi, capLo, keepHi, keepLo;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset hilo", {hiOut, loOut}, 64'h0);
    checkOutput("reset busy/done", {62'h0, busyOut, doneOut}, 64'h0);
    @(negedge clk); rstN = 1'b1;

    // Signed multiply with a cycle-by-cycle look at busy and done.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFD, 32'h0000_0007);
    checkOutput("mul busy after start", {62'h0, busyOut, doneOut}, 64'h2);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k < 4) checkOutput($sformatf("mul busy edge %0d", k), {62'h0, busyOut, doneOut}, 64'h2);
    end
    checkOutput("mul done edge 4", {62'h0, busyOut, doneOut}, 64'h1);
    checkOutput("mul -3*7", {hiOut, loOut}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(posedge clk); #1;
    checkOutput("mul done pulse ends", {63'h0, doneOut}, 64'h0);

    // Unsigned divide; operands and signedness wiggled while busy must not matter.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd100, 32'd7);
    opA = 32'hDEAD_BEEF; opB = 32'h0000_0003; unsignedOp = 1'b0;
    waitDone(40, c);
    checkOutput("divu latency", 64'(c), 64'd33);
    checkOutput("divu 100/7", {hiOut, loOut}, {32'd2, 32'd14});

    divCheck("div -7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    divCheck("div 7/-2", 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
    divCheck("div MIN/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    divCheck("divu big", 1'b1, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F);
    divCheck("divu 5/0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'h0000_0005);

    // Signed divide by zero with start_div held during the first busy cycles.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
    doneCount = 0; doneAt = -1; capHi = '0; capLo = '0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      startDiv = (i < 10); opA = 32'd77; opB = 32'd3;
      @(posedge clk); #1;
      if (doneOut) begin doneCount++; doneAt = i + 1; capHi = hiOut; capLo = loOut; end
    end
    startDiv = 1'b0;
    checkOutput("div0 single done", 64'(doneCount), 64'd1);
    checkOutput("div0 latency", 64'(doneAt), 64'd33);
    checkOutput("div 5/0", {capHi, capLo}, {32'h0000_0005, 32'hFFFF_FFFF});

    mulCheck("mulu max", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    mulCheck("mul -1*-1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    mulCheck("mul MIN*MIN", 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

    // Both starts together: the multiply wins.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd6, 32'd3);
    waitDone(40, c);
    checkOutput("mul+div start latency", 64'(c), 64'd4);
    checkOutput("mul+div start takes mul", {hiOut, loOut}, 64'd18);

    // HI/LO moves while idle.
    @(negedge clk); mtHi = 1'b1; wData = 32'h0000_1234;
    @(posedge clk); #1; mtHi = 1'b0;
    checkOutput("mthi idle", 64'(hiOut), 64'h1234);
    @(negedge clk); mtLo = 1'b1; wData = 32'h0000_5678;
    @(posedge clk); #1; mtLo = 1'b0;
    checkOutput("mtlo idle", {hiOut, loOut}, {32'h1234, 32'h5678});
    @(negedge clk); mtHi = 1'b1; mtLo = 1'b1; wData = 32'h0000_ABCD;
    @(posedge clk); #1; mtHi = 1'b0; mtLo = 1'b0;
    checkOutput("mthi+mtlo idle", {hiOut, loOut}, {32'hABCD, 32'hABCD});

    // Move with the start edge commits, move during busy is dropped.
    @(negedge clk);
    startMul = 1'b1; unsignedOp = 1'b0; opA = 32'd3; opB = 32'd5; mtHi = 1'b1; wData = 32'h0000_1111;
    @(posedge clk); #1; startMul = 1'b0; mtHi = 1'b0;
    checkOutput("mthi with start", {hiOut, 31'h0, busyOut}, {32'h1111, 32'h1});
    @(negedge clk); mtHi = 1'b1; wData = 32'h0000_9999;
    @(posedge clk); #1; mtHi = 1'b0;
    checkOutput("mthi busy ignored", 64'(hiOut), 64'h1111);
    waitDone(10, c);
    checkOutput("mul after moves latency", 64'(c), 64'd3);
    checkOutput("mul 3*5", {hiOut, loOut}, 64'd15);

`ifdef MDU_CANCEL_EN
    keepHi = hiOut; keepLo = loOut;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    @(negedge clk); cancelIn = 1'b1;
    @(posedge clk); #1; cancelIn = 1'b0;
    checkOutput("cancel busy/done", {62'h0, busyOut, doneOut}, 64'h0);
    checkOutput("cancel hilo kept", {hiOut, loOut}, {keepHi, keepLo});
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (doneOut) doneCount++;
    end
    checkOutput("cancel no done", 64'(doneCount), 64'd0);
    @(negedge clk); cancelIn = 1'b1; startMul = 1'b1; opA = 32'd2; opB = 32'd2;
    @(posedge clk); #1; cancelIn = 1'b0; startMul = 1'b0;
    checkOutput("cancel suppresses start", 64'(busyOut), 64'h0);
`else
    keepHi = '0; keepLo = '0;
`endif

    // Asynchronous reset in the middle of a divide.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("reset mid-div hilo", {hiOut, loOut}, 64'h0);
    checkOutput("reset mid-div busy/done", {62'h0, busyOut, doneOut}, 64'h0);
    @(negedge clk); rstN = 1'b1;
    mulCheck("mul after reset", 1'b0, 32'hFFFF_FFFE, 32'd4, 64'hFFFF_FFFF_FFFF_FFF8);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
